fetch_ctrl: RTL

- Instruction-fetch sequencer that owns the architectural PC register.
- Drives a variable-latency instruction ROM through a req/ack handshake.
- Presents each fetched instruction to decode through a valid/ready handshake.
- Applies redirects (taken branch, jal, jalr targets computed by the next-PC logic), discards in-flight fetches made stale by a redirect, and retries fetches that time out.

---
 rtl/fetch_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer. Owns the architectural PC, drives
//               a variable-latency instruction ROM over req/ack, and hands
//               fetched words to decode over valid/ready. Handles redirects,
//               drops responses made stale by a redirect, and retries fetches
//               that the ROM never acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        irom_req,
    output logic [31:0] irom_addr,
    input  logic        irom_ack,
    input  logic [31:0] irom_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] pc,
    output logic        misalign,
    output logic        irom_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // Last counter value before a fetch is given up on.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_d;
    logic [31:0] pc_d;
    logic [31:0] irom_addr_d;
    logic        irom_req_d;
    logic        inst_valid_d;
    logic [31:0] inst_d;
    logic [31:0] inst_pc_d;
    logic        misalign_d;
    logic        irom_timeout_d;
    logic        discard, discard_d;
    logic [7:0]  wait_cnt, wait_cnt_d;
    logic [31:0] target;

    // Redirect targets are forced to word alignment; low bits only flag misalign.
    assign target = {redirect_pc[31:2], 2'b00};

    // Register every output and all FSM state; reset abandons any fetch in flight.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            irom_addr    <= RESET_PC;
            irom_req     <= 1'b0;
            inst_valid   <= 1'b0;
            inst         <= 32'h0;
            inst_pc      <= 32'h0;
            misalign     <= 1'b0;
            irom_timeout <= 1'b0;
            discard      <= 1'b0;
            wait_cnt     <= 8'h0;
        end else begin
            state        <= state_d;
            pc           <= pc_d;
            irom_addr    <= irom_addr_d;
            irom_req     <= irom_req_d;
            inst_valid   <= inst_valid_d;
            inst         <= inst_d;
            inst_pc      <= inst_pc_d;
            misalign     <= misalign_d;
            irom_timeout <= irom_timeout_d;
            discard      <= discard_d;
            wait_cnt     <= wait_cnt_d;
        end
    end

    // Next-state and next-output logic for the fetch sequencer.
    always_comb begin
        state_d        = state;
        pc_d           = pc;
        irom_addr_d    = irom_addr;
        inst_valid_d   = inst_valid;
        inst_d         = inst;
        inst_pc_d      = inst_pc;
        discard_d      = discard;
        wait_cnt_d     = wait_cnt;
        irom_timeout_d = 1'b0;
        misalign_d     = redirect_valid && (redirect_pc[1:0] != 2'b00);

        case (state)
            S_IDLE: begin
                if (redirect_valid) pc_d = target;
                state_d = S_ISSUE;
            end

            S_ISSUE: begin
                if (redirect_valid) begin
                    pc_d        = target;
                    irom_addr_d = target;
                end else begin
                    irom_addr_d = pc;
                end
                wait_cnt_d = 8'h0;
                discard_d  = 1'b0;
                state_d    = S_WAIT;
            end

            S_WAIT: begin
                // The issued request cannot be withdrawn, so a redirect only
                // moves pc and marks the outstanding response as stale.
                if (redirect_valid) pc_d = target;
                if (irom_ack) begin
                    if (!discard && !redirect_valid) begin
                        inst_d       = irom_rdata;
                        inst_pc_d    = irom_addr;
                        inst_valid_d = 1'b1;
                        pc_d         = irom_addr + 32'd4;
                        state_d      = S_HOLD;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt + 8'd1;
                    if (redirect_valid) discard_d = 1'b1;
                    if (wait_cnt == TIMEOUT_LAST) begin
                        irom_timeout_d = 1'b1;
                        state_d        = S_ISSUE;
                    end
                end
            end

            S_HOLD: begin
                // A redirect flushes the held instruction even if decode takes it.
                if (redirect_valid) begin
                    inst_valid_d = 1'b0;
                    pc_d         = target;
                    state_d      = S_ISSUE;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = S_ISSUE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        irom_req_d = (state_d == S_WAIT);
    end

endmodule
`default_nettype wire
